// File: rtl/arb_pkg.sv
// arb_pkg: shared types, widths and the chain-order priority helper for the arbiter client bank
package arb_pkg;
  localparam int N_CLIENTS = 4;
  typedef enum logic {ST_IDLE, ST_OWN} state_e;
  function automatic int pend_cnt_w(input int pend_max);
    return $clog2(pend_max + 1);
  endfunction
  function automatic int beat_w(input int burst_len);
    return burst_len > 1 ? $clog2(burst_len) : 1;
  endfunction
  function automatic int lowest_set(input logic [31:0] v, input int n);
    int r;
    r = n;
    for (int i = n - 1; i >= 0; i--) r = v[i] ? i : r;
    return r;
  endfunction
endpackage

// File: rtl/arb_pend_counter.sv
// arb_pend_counter: saturating pending-transaction counter for one client
//   clk, rst_n : clock, async active-low reset
//   inc_i      : new command (dropped when full unless a tenure starts in the same cycle)
//   dec_i      : tenure start for this client
//   cnt_o      : current pending count
//   full_o     : count equals PEND_MAX
module arb_pend_counter #(
  parameter int PEND_MAX = 3,
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          full_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  logic up;
  always_comb begin
    up = inc_i && (cnt_q != CW'(PEND_MAX) || dec_i);
    cnt_d = up && !dec_i ? cnt_q + CW'(1) : !up && dec_i ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
  assign full_o = cnt_q == CW'(PEND_MAX);
endmodule

// File: rtl/arb_client_bank.sv
// arb_client_bank: requester bank for the daisy-chain arbiter; turns grants into locked BURST_LEN-cycle tenures
//   clk, rst_n   : clock, async active-low reset
//   cmd_i        : per-client one-cycle command pulses
//   arb_req_o    : request vector to arbiter; arb_gnt_i : grant vector back (combinational)
//   own_valid_o  : tenure active; own_o : one-hot owner; beat_o : beat index; done_o : last-beat pulse
//   pend_full_o  : per-client pending count saturated
//   err_o        : sticky grant protocol error, built only with ARB_CLIENT_GRANT_CHECK_EN
module arb_client_bank
  import arb_pkg::*;
#(
  parameter int N = N_CLIENTS,
  parameter int BURST_LEN = 4,
  parameter int PEND_MAX = 3,
  localparam int CW = pend_cnt_w(PEND_MAX),
  localparam int BW = beat_w(BURST_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [0:N-1]  cmd_i,
  output logic [0:N-1]  arb_req_o,
  input  logic [0:N-1]  arb_gnt_i,
  output logic          own_valid_o,
  output logic [0:N-1]  own_o,
  output logic [BW-1:0] beat_o,
  output logic [0:N-1]  done_o,
  output logic [0:N-1]  pend_full_o,
  output logic          err_o
);
  state_e state_q, state_d;
  logic [0:N-1] own_q, own_d, req_v, start;
  logic [BW-1:0] beat_q, beat_d;
  logic [31:0] vld;
  logic go, last;
  int k;
  for (genvar g = 0; g < N; g++) begin : g_cnt
    logic [CW-1:0] cnt;
    arb_pend_counter #(.PEND_MAX(PEND_MAX), .CW(CW)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (cmd_i[g]),
      .dec_i (start[g]),
      .cnt_o (cnt),
      .full_o(pend_full_o[g])
    );
    assign req_v[g] = cnt != '0;
  end
  // Grant bits of non-requesting clients are masked before picking the owner.
  always_comb begin
    vld = '0;
    for (int i = 0; i < N; i++) vld[i] = arb_gnt_i[i] & req_v[i];
    k = lowest_set(vld, N);
    go = state_q == ST_IDLE && vld != '0;
    last = state_q == ST_OWN && beat_q == BW'(BURST_LEN - 1);
    for (int i = 0; i < N; i++) start[i] = go && k == i;
    state_d = go ? ST_OWN : last ? ST_IDLE : state_q;
    own_d = last ? '0 : own_q | start;
    beat_d = state_q == ST_OWN && !last ? beat_q + BW'(1) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      own_q <= '0;
      beat_q <= '0;
    end else begin
      state_q <= state_d;
      own_q <= own_d;
      beat_q <= beat_d;
    end
  assign arb_req_o = state_q == ST_OWN ? own_q : req_v;
  assign own_valid_o = state_q == ST_OWN;
  assign own_o = own_q;
  assign beat_o = beat_q;
  assign done_o = last ? own_q : '0;
`ifdef ARB_CLIENT_GRANT_CHECK_EN
  logic err_q, err_d, bad;
  always_comb begin
    bad = state_q == ST_OWN ? arb_gnt_i != own_q
        : (arb_gnt_i & (arb_gnt_i - N'(1))) != '0 || (arb_gnt_i & ~req_v) != '0;
    err_d = err_q | bad;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) err_q <= 1'b0;
    else err_q <= err_d;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_arb_client_bank.sv
// tb_arb_client_bank: directed bench with a priority-chain arbiter model and a grant stub
module tb_arb_client_bank;
`ifdef ARB_CLIENT_GRANT_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [0:3] cmd = '0, req, gnt, own, done, full, stub_val = '0, arb_gnt;
  logic stub = 1'b0, own_valid, err;
  logic [1:0] beat;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  always_comb begin
    arb_gnt = '0;
    for (int i = 0; i < 4; i++) if (req[i] && arb_gnt == '0) arb_gnt[i] = 1'b1;
  end
  assign gnt = stub ? stub_val : arb_gnt;
  arb_client_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_i      (cmd),
    .arb_req_o  (req),
    .arb_gnt_i  (gnt),
    .own_valid_o(own_valid),
    .own_o      (own),
    .beat_o     (beat),
    .done_o     (done),
    .pend_full_o(full),
    .err_o      (err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #3;
    checks++; if ({req, own, done, full} !== 16'h0) begin errors++; $display("FAIL reset_vec got=%h exp=0000", {req, own, done, full}); end
    checks++; if ({own_valid, beat, err} !== 4'h0) begin errors++; $display("FAIL reset_ctl got=%b exp=0000", {own_valid, beat, err}); end
    #9 rst_n = 1'b1;
    tick;
  endtask
  task automatic test_single;
    cmd = 4'b0100; tick; cmd = '0;
    checks++; if (req !== 4'b0100 || own_valid !== 1'b0) begin errors++; $display("FAIL single_req got=%b/%b exp=0100/0", req, own_valid); end
    for (int b = 0; b < 4; b++) begin
      tick;
      checks++; if (own !== 4'b0100 || own_valid !== 1'b1 || beat !== 2'(b)) begin errors++; $display("FAIL single_own b=%0d got=%b/%b/%0d exp=0100/1/%0d", b, own, own_valid, beat, b); end
      checks++; if (done !== (b == 3 ? 4'b0100 : 4'b0000)) begin errors++; $display("FAIL single_done b=%0d got=%b", b, done); end
    end
    tick;
    checks++; if (req !== 4'b0000 || own !== 4'b0000 || own_valid !== 1'b0) begin errors++; $display("FAIL single_end got=%b/%b/%b exp=0000/0000/0", req, own, own_valid); end
  endtask
  task automatic test_priority;
    logic [0:3] rem [4] = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    logic [0:3] exp_own [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    cmd = 4'b1111; tick; cmd = '0;
    for (int j = 0; j < 4; j++) begin
      checks++; if (req !== rem[j] || own_valid !== 1'b0) begin errors++; $display("FAIL prio_idle j=%0d got=%b/%b exp=%b/0", j, req, own_valid, rem[j]); end
      for (int b = 0; b < 4; b++) begin
        tick;
        checks++; if (own !== exp_own[j] || beat !== 2'(b)) begin errors++; $display("FAIL prio_own j=%0d b=%0d got=%b/%0d exp=%b/%0d", j, b, own, beat, exp_own[j], b); end
        checks++; if (done !== (b == 3 ? exp_own[j] : 4'b0000)) begin errors++; $display("FAIL prio_done j=%0d b=%0d got=%b", j, b, done); end
      end
      tick;
    end
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL prio_end got=%b exp=0000", req); end
  endtask
  task automatic test_lock;
    cmd = 4'b0010; tick; cmd = '0;
    tick; tick;
    cmd = 4'b1000;
    checks++; if (beat !== 2'd1 || own !== 4'b0010) begin errors++; $display("FAIL lock_beat1 got=%b/%0d exp=0010/1", own, beat); end
    tick; cmd = '0;
    checks++; if (req !== 4'b0010 || own !== 4'b0010) begin errors++; $display("FAIL lock_b2 got=%b/%b exp=0010/0010", req, own); end
    tick;
    checks++; if (req !== 4'b0010 || done !== 4'b0010) begin errors++; $display("FAIL lock_b3 got=%b/%b exp=0010/0010", req, done); end
    tick;
    checks++; if (req !== 4'b1000 || own_valid !== 1'b0) begin errors++; $display("FAIL lock_idle got=%b/%b exp=1000/0", req, own_valid); end
    tick;
    checks++; if (own !== 4'b1000 || beat !== 2'd0) begin errors++; $display("FAIL lock_next got=%b/%0d exp=1000/0", own, beat); end
    tick; tick; tick;
    checks++; if (done !== 4'b1000) begin errors++; $display("FAIL lock_done got=%b exp=1000", done); end
    tick;
  endtask
  task automatic test_saturation;
    int n = 0;
    stub = 1'b1; stub_val = '0;
    for (int p = 0; p < 5; p++) begin
      cmd = 4'b0001; tick; cmd = '0;
      if (p == 1) begin checks++; if (full !== 4'b0000) begin errors++; $display("FAIL sat_two got=%b exp=0000", full); end end
    end
    checks++; if (full !== 4'b0001 || req !== 4'b0001 || own_valid !== 1'b0) begin errors++; $display("FAIL sat_full got=%b/%b/%b exp=0001/0001/0", full, req, own_valid); end
    stub = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick;
      if (done == 4'b0001) n++;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL sat_tenures got=%0d exp=3", n); end
    checks++; if (req !== 4'b0000 || full !== 4'b0000) begin errors++; $display("FAIL sat_end got=%b/%b exp=0000/0000", req, full); end
  endtask
  task automatic test_concurrent;
    cmd = 4'b0100; tick;
    checks++; if (req !== 4'b0100 || own_valid !== 1'b0) begin errors++; $display("FAIL conc_idle got=%b/%b exp=0100/0", req, own_valid); end
    tick; cmd = '0;
    checks++; if (own !== 4'b0100 || full !== 4'b0000) begin errors++; $display("FAIL conc_own got=%b/%b exp=0100/0000", own, full); end
    tick; tick; tick; tick;
    checks++; if (req !== 4'b0100 || own_valid !== 1'b0) begin errors++; $display("FAIL conc_second_req got=%b/%b exp=0100/0", req, own_valid); end
    tick;
    checks++; if (own !== 4'b0100 || beat !== 2'd0) begin errors++; $display("FAIL conc_second_own got=%b/%0d exp=0100/0", own, beat); end
    tick; tick; tick;
    checks++; if (done !== 4'b0100) begin errors++; $display("FAIL conc_done got=%b exp=0100", done); end
    tick;
    checks++; if (req !== 4'b0000) begin errors++; $display("FAIL conc_end got=%b exp=0000", req); end
  endtask
  task automatic test_bad_grant;
    stub = 1'b1; stub_val = 4'b1100;
    tick;
    checks++; if (own_valid !== 1'b0 || err !== ERR_EN) begin errors++; $display("FAIL bad_idle got=%b/%b exp=0/%b", own_valid, err, ERR_EN); end
    cmd = 4'b0100; tick; cmd = '0;
    tick;
    checks++; if (own !== 4'b0100 || own_valid !== 1'b1) begin errors++; $display("FAIL bad_mask got=%b/%b exp=0100/1", own, own_valid); end
    stub = 1'b0;
    tick; tick; tick;
    checks++; if (done !== 4'b0100 || err !== ERR_EN) begin errors++; $display("FAIL bad_sticky got=%b/%b exp=0100/%b", done, err, ERR_EN); end
    tick;
    rst_n = 1'b0; #2;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL bad_reset got=%b exp=0", err); end
    #3 rst_n = 1'b1;
    tick;
  endtask
  task automatic test_reset_mid;
    cmd = 4'b0001; tick; cmd = '0;
    tick; tick; tick;
    checks++; if (beat !== 2'd2 || own !== 4'b0001) begin errors++; $display("FAIL mid_pre got=%b/%0d exp=0001/2", own, beat); end
    #2 rst_n = 1'b0; #1;
    checks++; if ({req, own, done} !== 12'h0 || own_valid !== 1'b0 || beat !== 2'd0) begin errors++; $display("FAIL mid_async got=%h/%b/%0d exp=000/0/0", {req, own, done}, own_valid, beat); end
    tick;
    checks++; if (done !== 4'b0000 || own_valid !== 1'b0) begin errors++; $display("FAIL mid_hold got=%b/%b exp=0000/0", done, own_valid); end
    #3 rst_n = 1'b1;
    tick;
    checks++; if (req !== 4'b0000 || own_valid !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_after got=%b/%b/%b exp=0000/0/0", req, own_valid, err); end
  endtask
  initial begin
    test_reset;
    test_single;
    test_priority;
    test_lock;
    test_saturation;
    test_concurrent;
    test_reset_mid;
    test_bad_grant;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/arb_client_bank.md
Name: arb_client_bank

Overview:
- Requester-side companion to the daisy-chain priority arbiter.
- Accepts per-client command pulses and counts pending transactions per client.
- Drives the arbiter request vector and consumes its grant vector.
- Each grant becomes a locked bus tenure of BURST_LEN cycles. Other requests are masked during a tenure so the combinational grant stays stable.

Parameters:
- N, 4, number of clients; index 0 is highest priority, matching arbiter chain order.
- BURST_LEN, 4, cycles of bus ownership per grant (>=1).
- PEND_MAX, 3, saturation limit of each client's pending counter (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- cmd_i  input  [0:N-1]  one-cycle pulse per client = one new transaction
- arb_req_o  output  [0:N-1]  request vector to arbiter r
- arb_gnt_i  input  [0:N-1]  grant vector from arbiter g (combinational from arb_req_o)
- own_valid_o  output  1  high during a tenure
- own_o  output  [0:N-1]  one-hot current owner; all zero when idle
- beat_o  output  $clog2(BURST_LEN)  beat index within tenure, 0..BURST_LEN-1
- done_o  output  [0:N-1]  one-cycle pulse on the owner's bit at the last beat
- pend_full_o  output  [0:N-1]  client pending count == PEND_MAX
- err_o  output  1  sticky protocol error (see Optional Feature)

Behaviour:
- Reset (async assert, sync-free release):
  - All pending counts 0; state IDLE.
  - arb_req_o, own_o, done_o, pend_full_o = 0; own_valid_o = 0; beat_o = 0; err_o = 0.
- Pending counters, width $clog2(PEND_MAX+1):
  - cmd_i[i] increments count i unless it is at PEND_MAX.
  - At saturation the command is dropped silently; count holds.
  - Tenure start for client i decrements count i.
  - cmd_i[i] in the same cycle as tenure start for client i: net count unchanged.
- Request output (combinational from registered state):
  - IDLE: arb_req_o[i] = (count i != 0).
  - OWN: arb_req_o = own_o only.
- State IDLE:
  - If arb_gnt_i is nonzero, capture the lowest set index k, then next cycle:
    - state OWN, own_o = onehot(k), beat_o = 0, count k decremented.
  - A grant bit whose client is not requesting is ignored.
  - If arb_gnt_i has no valid bit, stay IDLE.
- State OWN:
  - own_valid_o = 1; beat_o increments each cycle.
  - When beat_o == BURST_LEN-1: done_o[k] = 1 that cycle; next state IDLE; own_o clears.
  - arb_gnt_i is not sampled during OWN.
- Mandatory turnaround: one IDLE cycle always separates consecutive tenures, even for the same client.
- Latency: cmd_i[i] pulse in cycle t (all idle) → arb_req_o[i] in t+1 → own_valid_o in t+2 → done_o in t+1+BURST_LEN.
- Throughput: one tenure per BURST_LEN+1 cycles.
- BURST_LEN == 1: tenure is a single cycle, with own_valid_o and done_o in the same cycle.
- Reset asserted mid-tenure: immediate return to reset values; no done_o pulse; pending work is lost.

Optional Feature:
- Macro ARB_CLIENT_GRANT_CHECK_EN.
- Defined: in IDLE, err_o sets and stays set until reset if arb_gnt_i is non-one-hot or grants a non-requesting client. In OWN, err_o sets if arb_gnt_i != own_o. Functional behaviour is otherwise identical.
- Undefined: err_o is tied to 0 and no check logic is built.

Decomposition:
- Shared package arb_pkg holds:
  - N_CLIENTS default constant
  - state enum (ST_IDLE, ST_OWN)
  - pend_cnt_t width function/localparam
  - lowest-set-index priority function shared with arbiter models
- Natural sub-module: arb_pend_counter, one saturating up/down counter per client, instantiated N times. The FSM stays in the top module.

Test Plan:
- Single request: cmd_i=0100 at cycle 2 → arb_req_o=0100 at 3; own_o=0100, own_valid_o=1 at cycles 4–7; done_o=0100 at 7; arb_req_o=0000 at 8.
- Priority order: cmd_i=1111 in one cycle → tenures in order 1000, 0100, 0010, 0001, each 4 cycles separated by one IDLE cycle; done_o order 0,1,2,3.
- Lock during tenure: client 2 owning, cmd_i=1000 at beat 1 → arb_req_o stays 0010 until done; client 0 is granted in the next IDLE cycle.
- Saturation: 5 pulses on client 3 with no grant (arbiter stubbed to 0) → count 3, pend_full_o=0001. Restoring the grant gives exactly 3 tenures.
- Concurrent cmd/start: client 1 count 1, cmd_i=0100 in the IDLE grant cycle → count stays 1, and a second tenure follows.
- Reset mid-tenure: rst_n low at beat 2 → outputs zero asynchronously; no done_o pulse. With ARB_CLIENT_GRANT_CHECK_EN defined, forcing arb_gnt_i=1100 in IDLE sets err_o=1 until reset.
